// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, twiddle tables and FSM encoding for the FFT twiddle stage
package fft_pkg;

  localparam int DW     = 16;
  localparam int WW     = 8;
  localparam int NUM_TW = 8;
  localparam int KW     = $clog2(NUM_TW);

  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [WW-1:0] tw_t;

  // W^k = TW_RE[k] + j*TW_IM[k], Q1.6 (64 = +1.0), k = 0..7 of N = 16
  localparam tw_t TW_RE [0:NUM_TW-1] = '{
    8'sd64, 8'sd59, 8'sd45, 8'sd24, 8'sd0, -8'sd24, -8'sd45, -8'sd59
  };
  localparam tw_t TW_IM [0:NUM_TW-1] = '{
    8'sd0, -8'sd24, -8'sd45, -8'sd59, -8'sd64, -8'sd59, -8'sd45, -8'sd24
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/twiddle_mult_seq_if.sv
// rtl/twiddle_mult_seq_if.sv - operand/result handshake bundle for the twiddle multiplier
interface twiddle_mult_seq_if import fft_pkg::*; ();

  logic            in_valid;
  logic            in_ready;
  data_t           a_re;
  data_t           a_im;
  logic [KW-1:0]   k;
  logic            out_valid;
  logic            out_ready;
  data_t           y_re;
  data_t           y_im;
  logic            busy;

  modport master (
    output in_valid, a_re, a_im, k, out_ready,
    input  in_ready, out_valid, y_re, y_im, busy
  );

  modport slave (
    input  in_valid, a_re, a_im, k, out_ready,
    output in_ready, out_valid, y_re, y_im, busy
  );

endinterface

// File: rtl/signed_multiplier.sv
// rtl/signed_multiplier.sv - 16b x Q1.6 8b sign-magnitude multiply, truncates toward zero
module signed_multiplier (
  input  logic signed [15:0] a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);

  logic [15:0] mag_a;
  logic [7:0]  mag_b;
  logic [23:0] mag_p;
  logic [15:0] mag_q;
  logic        neg;

  // -32768 maps to 0x8000, which is its correct unsigned magnitude
  assign mag_a = a[15] ? (~a + 16'd1) : a;
  assign mag_b = b[7]  ? (~b + 8'd1)  : b;
  assign mag_p = {8'd0, mag_a} * {16'd0, mag_b};
  assign mag_q = 16'(mag_p >> 6);
  assign neg   = a[15] ^ b[7];
  assign p     = neg ? $signed(~mag_q + 16'd1) : $signed(mag_q);

endmodule

// File: rtl/twiddle_mult_seq.sv
// rtl/twiddle_mult_seq.sv - complex A*W^k over four cycles of one shared real multiplier
module twiddle_mult_seq import fft_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  twiddle_mult_seq_if.slave  bus
);

  state_t      state;
  logic [1:0]  phase;
  data_t       ar, ai;
  tw_t         wr, wi;
  data_t       p0, p1, p2;
  data_t       y_re_q, y_im_q;
  logic        out_valid_q, in_ready_q, busy_q;

  data_t       mul_a;
  tw_t         mul_b;
  data_t       mul_p;

  // ph0 ar*wr, ph1 ai*wi, ph2 ar*wi, ph3 ai*wr
  assign mul_a = phase[0] ? ai : ar;
  assign mul_b = (phase[0] ^ phase[1]) ? wi : wr;

  signed_multiplier u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase       <= 2'd0;
      ar          <= '0;
      ai          <= '0;
      wr          <= '0;
      wi          <= '0;
      p0          <= '0;
      p1          <= '0;
      p2          <= '0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            ar         <= bus.a_re;
            ai         <= bus.a_im;
            wr         <= TW_RE[bus.k];
            wi         <= TW_IM[bus.k];
            phase      <= 2'd0;
            state      <= ST_MUL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_MUL: begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: p0 <= mul_p;
            2'd1: p1 <= mul_p;
            2'd2: p2 <= mul_p;
            default: begin
              // P3 is folded straight into the sum rather than parked in a register
              y_re_q      <= p0 - p1;
              y_im_q      <= p2 + mul_p;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end
          endcase
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.y_re      = y_re_q;
  assign bus.y_im      = y_im_q;

endmodule

// File: tb/tb_twiddle_mult_seq.sv
// tb/tb_twiddle_mult_seq.sv - self-checking bench for twiddle_mult_seq against an arithmetic model
module tb_twiddle_mult_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  twiddle_mult_seq_if bus ();

  twiddle_mult_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int tw_re [8] = '{64, 59, 45, 24, 0, -24, -45, -59};
  int tw_im [8] = '{0, -24, -45, -59, -64, -59, -45, -24};

  function automatic int wrap16(longint v);
    longint m;
    m = v & 64'hFFFF;
    return (m >= 32768) ? int'(m - 65536) : int'(m);
  endfunction

  function automatic int real_mul(int a, int w);
    longint m;
    m = longint'(a < 0 ? -a : a) * longint'(w < 0 ? -w : w);
    m = m / 64;
    if ((a < 0) != (w < 0)) m = -m;
    return wrap16(m);
  endfunction

  task automatic model(input int a_r, input int a_i, input int kk, output int yr, output int yi);
    yr = wrap16(longint'(real_mul(a_r, tw_re[kk])) - longint'(real_mul(a_i, tw_im[kk])));
    yi = wrap16(longint'(real_mul(a_r, tw_im[kk])) + longint'(real_mul(a_i, tw_re[kk])));
  endtask

  function automatic int got_re();
    return int'($signed(bus.y_re));
  endfunction

  function automatic int got_im();
    return int'($signed(bus.y_im));
  endfunction

  // Starts and ends at a negedge; returns once out_valid is seen or the budget expires
  task automatic launch(input int a_r, input int a_i, input int kk,
                        output int lat, output bit saw_ready, output bit saw_idle, output bit timeout);
    bus.a_re     = a_r[15:0];
    bus.a_im     = a_i[15:0];
    bus.k        = kk[2:0];
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0; saw_ready = 0; saw_idle = 0; timeout = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.in_ready) saw_ready = 1;
      if (!bus.busy) saw_idle = 1;
      if (bus.out_valid) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.y_re !== 16'd0 || bus.y_im !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b y=(%0d,%0d) required 1 0 0 (0,0)",
               bus.in_ready, bus.out_valid, bus.busy, got_re(), got_im());
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_identity();
    int lat; bit sr, si, to;
    bus.out_ready = 1'b1;
    launch(1000, -500, 0, lat, sr, si, to);
    checks++;
    if (to !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL identity_latency: timeout=%b latency=%0d required 0 4", to, lat);
    end
    checks++;
    if (sr !== 1'b0 || si !== 1'b0) begin
      errors++;
      $display("FAIL identity_handshake: in_ready_seen=%b not_busy_seen=%b required 0 0", sr, si);
    end
    checks++;
    if (got_re() != 1000 || got_im() != -500) begin
      errors++;
      $display("FAIL identity_value: y=(%0d,%0d) required (1000,-500)", got_re(), got_im());
    end
    consume();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL identity_release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_rotations();
    int vec [5][5] = '{
      '{1000, -500, 4, -500, -1000},
      '{64, 0, 2, 45, -45},
      '{100, 0, 1, 92, -37},
      '{-100, 0, 1, -92, 37},
      '{-32768, 0, 0, -32768, 0}
    };
    int lat; bit sr, si, to;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      launch(vec[i][0], vec[i][1], vec[i][2], lat, sr, si, to);
      checks++;
      if (to !== 1'b0 || got_re() != vec[i][3] || got_im() != vec[i][4]) begin
        errors++;
        $display("FAIL rotation_%0d: timeout=%b y=(%0d,%0d) required (%0d,%0d)",
                 i, to, got_re(), got_im(), vec[i][3], vec[i][4]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat, er, ei; bit sr, si, to;
    model(300, -700, 3, er, ei);
    bus.out_ready = 1'b0;
    launch(300, -700, 3, lat, sr, si, to);
    checks++;
    if (to !== 1'b0 || got_re() != er || got_im() != ei) begin
      errors++;
      $display("FAIL bp_value: timeout=%b y=(%0d,%0d) required (%0d,%0d)", to, got_re(), got_im(), er, ei);
    end
    bus.a_re = 16'd1; bus.a_im = 16'd1; bus.k = 3'd5; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got_re() != er || got_im() != ei) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b y=(%0d,%0d) required 1 0 (%0d,%0d)",
                 i, bus.out_valid, bus.in_ready, got_re(), got_im(), er, ei);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_accept: busy=%b in_ready=%b required 0 1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    bus.out_ready = 1'b1;
    bus.a_re = 16'd1234; bus.a_im = 16'd4321; bus.k = 3'd3; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.y_re !== 16'd0 || bus.y_im !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_state: in_ready=%b out_valid=%b busy=%b y=(%0d,%0d) required 1 0 0 (0,0)",
               bus.in_ready, bus.out_valid, bus.busy, got_re(), got_im());
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_drop: out_valid_seen=%b in_ready=%b required 0 1", seen, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int va [8], vb [8], er [8], ei [8], out_cyc [8];
    int idx, nout, cyc;
    for (int i = 0; i < 8; i++) begin
      va[i] = int'($urandom_range(0, 65535)) - 32768;
      vb[i] = int'($urandom_range(0, 65535)) - 32768;
      model(va[i], vb[i], i, er[i], ei[i]);
    end
    bus.out_ready = 1'b1;
    idx = 0; nout = 0; cyc = 0;
    for (int t = 0; t < 120 && nout < 8; t++) begin
      if (bus.in_ready) begin
        if (idx < 8) begin
          bus.a_re = va[idx][15:0]; bus.a_im = vb[idx][15:0]; bus.k = idx[2:0];
          bus.in_valid = 1'b1;
          idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.out_valid) begin
        out_cyc[nout] = cyc;
        checks++;
        if (got_re() != er[nout] || got_im() != ei[nout]) begin
          errors++;
          $display("FAIL b2b_value_k%0d: y=(%0d,%0d) required (%0d,%0d)",
                   nout, got_re(), got_im(), er[nout], ei[nout]);
        end
        nout++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (nout != 8) begin
      errors++;
      $display("FAIL b2b_count: results=%0d required 8", nout);
    end
    for (int i = 1; i < nout; i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i-1] != 6) begin
        errors++;
        $display("FAIL b2b_interval_%0d: cycles=%0d required 6", i, out_cyc[i] - out_cyc[i-1]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    int a_r, a_i, kk, er, ei, lat; bit sr, si, to;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: begin a_r = 32767;  a_i = -32768; end
        1: begin a_r = -32768; a_i = -32768; end
        default: begin
          a_r = int'($urandom_range(0, 65535)) - 32768;
          a_i = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      kk = int'($urandom_range(0, 7));
      model(a_r, a_i, kk, er, ei);
      launch(a_r, a_i, kk, lat, sr, si, to);
      checks++;
      if (to !== 1'b0 || got_re() != er || got_im() != ei) begin
        errors++;
        $display("FAIL random_%0d: A=(%0d,%0d) k=%0d timeout=%b y=(%0d,%0d) required (%0d,%0d)",
                 i, a_r, a_i, kk, to, got_re(), got_im(), er, ei);
      end
      consume();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_re      = '0;
    bus.a_im      = '0;
    bus.k         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_identity();
    test_rotations();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
